// File: rtl/tbird_seq_gen_if.sv
// Lamp request/drive bundle between the switch debouncers and the lamp drivers.
// The master drives the four level requests; the slave (sequencer) drives the lamps.
interface tbird_seq_gen_if #(
    parameter int N_LAMPS = 3
);
    logic                   left;
    logic                   right;
    logic                   haz;
    logic                   brake;
    logic [2*N_LAMPS-1:0]   light;

    modport master (
        output left, right, haz, brake,
        input  light
    );

    modport slave (
        input  left, right, haz, brake,
        output light
    );
endinterface

// File: rtl/tbird_seq_gen.sv
// Parametrised Thunderbird tail-light sequencer: outward-running turn sequences,
// alternating hazard flash, brake overlay on every non-sequencing side.
module tbird_seq_gen #(
    parameter int N_LAMPS = 3,
    parameter int DIV     = 1
) (
    input  logic            clk,
    input  logic            reset,
    tbird_seq_gen_if.slave  bus
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW = $clog2(N_LAMPS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [KW-1:0] K_MAX   = KW'(N_LAMPS);

    typedef enum logic [1:0] {
        M_IDLE,
        M_LEFT,
        M_RIGHT,
        M_HAZ_ON
    } mode_t;

    typedef enum logic [1:0] {
        R_NONE,
        R_LEFT,
        R_RIGHT,
        R_HAZ
    } req_t;

    logic [CW-1:0]          r_cnt;
    mode_t                  r_mode;
    logic [KW-1:0]          r_k;
    logic [2*N_LAMPS-1:0]   r_light;

    logic                   w_tick;
    req_t                   w_req;
    mode_t                  w_mode_nxt;
    logic [KW-1:0]          w_k_nxt;
    logic                   w_continue;
    logic [2*N_LAMPS-1:0]   w_light_nxt;

    assign w_tick    = (r_cnt == CNT_MAX);
    assign bus.light = r_light;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_mode  <= M_IDLE;
            r_k     <= '0;
            r_light <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
            r_mode  <= w_mode_nxt;
            r_k     <= w_k_nxt;
            r_light <= w_light_nxt;
        end
    end

    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_req       = R_NONE;
        w_mode_nxt  = r_mode;
        w_k_nxt     = r_k;
        w_continue  = 1'b0;
        w_light_nxt = '0;

        if (bus.haz || (bus.left && bus.right)) begin
            w_req = R_HAZ;
        end else if (bus.left) begin
            w_req = R_LEFT;
        end else if (bus.right) begin
            w_req = R_RIGHT;
        end

        w_continue = ((r_mode == M_LEFT)  && (w_req == R_LEFT)) ||
                     ((r_mode == M_RIGHT) && (w_req == R_RIGHT));

        if (w_tick) begin
            unique case (r_mode)
                M_IDLE: begin
                    unique case (w_req)
                        R_HAZ: begin
                            w_mode_nxt = M_HAZ_ON;
                            w_k_nxt    = '0;
                        end
                        R_LEFT: begin
                            w_mode_nxt = M_LEFT;
                            w_k_nxt    = KW'(1);
                        end
                        R_RIGHT: begin
                            w_mode_nxt = M_RIGHT;
                            w_k_nxt    = KW'(1);
                        end
                        default: begin
                            w_mode_nxt = M_IDLE;
                            w_k_nxt    = '0;
                        end
                    endcase
                end
                M_LEFT, M_RIGHT: begin
                    // A finished or aborted sequence always shows one off step
                    // before any new direction can start.
                    if (w_continue && (r_k != K_MAX)) begin
                        w_k_nxt = r_k + KW'(1);
                    end else if (!w_continue && (w_req == R_HAZ)) begin
                        w_mode_nxt = M_HAZ_ON;
                        w_k_nxt    = '0;
                    end else begin
                        w_mode_nxt = M_IDLE;
                        w_k_nxt    = '0;
                    end
                end
                default: begin
                    w_mode_nxt = M_IDLE;
                    w_k_nxt    = '0;
                end
            endcase
        end

        // Lamps are registered from the next state, so the brake overlay
        // follows the pedal with one cycle of latency between ticks.
        unique case (w_mode_nxt)
            M_LEFT: begin
                for (int i = 0; i < N_LAMPS; i++) begin
                    if (i < int'(w_k_nxt)) w_light_nxt[N_LAMPS+i] = 1'b1;
                end
                if (bus.brake) w_light_nxt[N_LAMPS-1:0] = '1;
            end
            M_RIGHT: begin
                for (int i = 0; i < N_LAMPS; i++) begin
                    if (i < int'(w_k_nxt)) w_light_nxt[N_LAMPS-1-i] = 1'b1;
                end
                if (bus.brake) w_light_nxt[2*N_LAMPS-1:N_LAMPS] = '1;
            end
            M_HAZ_ON: begin
                w_light_nxt = '1;
            end
            default: begin
                if (bus.brake) w_light_nxt = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_tbird_seq_gen.sv
// Directed bench: four sequencer instances (N3/DIV1, N3/DIV4, N1, N8) sharing
// one clock and reset, exercised one after another with hand-computed lamp values.
module tb_tbird_seq_gen;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    tbird_seq_gen_if #(.N_LAMPS(3)) ia ();
    tbird_seq_gen_if #(.N_LAMPS(3)) ib ();
    tbird_seq_gen_if #(.N_LAMPS(1)) ic ();
    tbird_seq_gen_if #(.N_LAMPS(8)) id ();

    tbird_seq_gen #(.N_LAMPS(3), .DIV(1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    tbird_seq_gen #(.N_LAMPS(3), .DIV(4)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));
    tbird_seq_gen #(.N_LAMPS(1), .DIV(1)) dut_c (.clk(clk), .reset(reset), .bus(ic.slave));
    tbird_seq_gen #(.N_LAMPS(8), .DIV(1)) dut_d (.clk(clk), .reset(reset), .bus(id.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        {ia.left, ia.right, ia.haz, ia.brake} = 4'b0;
        {ib.left, ib.right, ib.haz, ib.brake} = 4'b0;
        {ic.left, ic.right, ic.haz, ic.brake} = 4'b0;
        {id.left, id.right, id.haz, id.brake} = 4'b0;

        // ---- N=3, DIV=1: reset state and left sequence
        step();
        step();
        check("a_reset", 16'(ia.light), 16'b000000);
        check("b_reset", 16'(ib.light), 16'b000000);
        reset = 1'b0;
        ia.left = 1'b1;
        step(); check("a_left_k1", 16'(ia.light), 16'b001000);
        step(); check("a_left_k2", 16'(ia.light), 16'b011000);
        step(); check("a_left_k3", 16'(ia.light), 16'b111000);
        step(); check("a_left_off", 16'(ia.light), 16'b000000);
        step(); check("a_left_rest", 16'(ia.light), 16'b001000);
        ia.left = 1'b0;
        step(); check("a_left_drop", 16'(ia.light), 16'b000000);

        // ---- right sequence, hazard abort, return via IDLE
        ia.right = 1'b1;
        step(); check("a_right_k1", 16'(ia.light), 16'b000100);
        step(); check("a_right_k2", 16'(ia.light), 16'b000110);
        ia.haz = 1'b1;
        step(); check("a_haz_on1", 16'(ia.light), 16'b111111);
        step(); check("a_haz_off", 16'(ia.light), 16'b000000);
        step(); check("a_haz_on2", 16'(ia.light), 16'b111111);
        ia.haz = 1'b0;
        step(); check("a_haz_exit", 16'(ia.light), 16'b000000);
        step(); check("a_right_again", 16'(ia.light), 16'b000100);
        ia.right = 1'b0;
        step(); check("a_right_drop", 16'(ia.light), 16'b000000);

        // ---- left and right together behave as hazard
        ia.left  = 1'b1;
        ia.right = 1'b1;
        step(); check("a_lr_on1", 16'(ia.light), 16'b111111);
        step(); check("a_lr_off", 16'(ia.light), 16'b000000);
        step(); check("a_lr_on2", 16'(ia.light), 16'b111111);
        ia.left  = 1'b0;
        ia.right = 1'b0;
        step(); check("a_lr_exit", 16'(ia.light), 16'b000000);

        // ---- brake overlay
        ia.brake = 1'b1;
        step(); check("a_brk_idle", 16'(ia.light), 16'b111111);
        ia.left = 1'b1;
        step(); check("a_brk_k1", 16'(ia.light), 16'b001111);
        step(); check("a_brk_k2", 16'(ia.light), 16'b011111);
        step(); check("a_brk_k3", 16'(ia.light), 16'b111111);
        step(); check("a_brk_idle2", 16'(ia.light), 16'b111111);
        step(); check("a_brk_k1b", 16'(ia.light), 16'b001111);
        ia.brake = 1'b0;
        step(); check("a_brk_release", 16'(ia.light), 16'b011000);

        // ---- reset mid-sequence (now at k=2), left still held
        reset = 1'b1;
        step(); check("a_reset_mid", 16'(ia.light), 16'b000000);
        reset = 1'b0;
        step(); check("a_after_reset", 16'(ia.light), 16'b001000);
        ia.left = 1'b0;

        // ---- N=3, DIV=4: prescaled stepping
        reset = 1'b1;
        step();
        reset = 1'b0;
        ib.left = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step(); check($sformatf("b_pre_tick_e%0d", e), 16'(ib.light), 16'b000000);
        end
        step(); check("b_tick1", 16'(ib.light), 16'b001000);
        for (int e = 5; e <= 7; e++) begin
            step(); check($sformatf("b_hold_e%0d", e), 16'(ib.light), 16'b001000);
        end
        step(); check("b_tick2", 16'(ib.light), 16'b011000);
        repeat (4) step();
        check("b_tick3", 16'(ib.light), 16'b111000);
        repeat (4) step();
        check("b_tick4_off", 16'(ib.light), 16'b000000);
        ib.left = 1'b0;
        step(); check("b_e17", 16'(ib.light), 16'b000000);
        ib.left = 1'b1;
        step();
        step();
        ib.left = 1'b0;
        step(); check("b_pulse_ignored", 16'(ib.light), 16'b000000);
        repeat (3) step();
        ib.left = 1'b1;
        step(); check("b_tick6_left", 16'(ib.light), 16'b001000);
        ib.brake = 1'b1;
        step(); check("b_brake_on", 16'(ib.light), 16'b001111);
        ib.brake = 1'b0;
        step(); check("b_brake_off", 16'(ib.light), 16'b001000);
        step();
        step(); check("b_tick7", 16'(ib.light), 16'b011000);
        ib.left = 1'b0;

        // ---- N=1 and N=8 sweeps, DIV=1
        reset = 1'b1;
        step();
        check("c_reset", 16'(ic.light), 16'h0000);
        check("d_reset", 16'(id.light), 16'h0000);
        reset = 1'b0;
        ic.left = 1'b1;
        id.left = 1'b1;
        step();
        check("c_blink_on1", 16'(ic.light), 16'b10);
        check("d_left_k1", 16'(id.light), 16'h0100);
        step();
        check("c_blink_off", 16'(ic.light), 16'b00);
        check("d_left_k2", 16'(id.light), 16'h0300);
        step();
        check("c_blink_on2", 16'(ic.light), 16'b10);
        check("d_left_k3", 16'(id.light), 16'h0700);
        for (int k = 4; k <= 8; k++) begin
            step();
            check($sformatf("d_left_k%0d", k), 16'(id.light), 16'(((1 << k) - 1) << 8));
        end
        step(); check("d_left_off", 16'(id.light), 16'h0000);
        step(); check("d_left_restart", 16'(id.light), 16'h0100);
        ic.left = 1'b0;
        id.left = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
